mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SIZE, 1024, byte capacity of the shared memory; governs range checks.
REQ-002 MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all registers rise-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  instruction-fetch request (word read).
REQ-007 if_addr  in  32  fetch byte address.
REQ-008 if_gnt  out  1  fetch accepted this cycle (combinational).
REQ-009 if_rvalid  out  1  fetch response valid (registered).
REQ-010 if_rdata  out  32  fetch response data (registered).
REQ-011 if_err  out  1  fetch response error, qualified by if_rvalid.
REQ-012 d_req  in  1  load/store request.
REQ-013 d_we  in  1  1 = store, 0 = load.
REQ-014 d_addr  in  32  data byte address.
REQ-015 d_width  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-016 d_usignext  in  1  zero-extend load when 1.
REQ-017 d_wdata  in  32  store data.
REQ-018 d_gnt  out  1  data request accepted this cycle (combinational).
REQ-019 d_rvalid / d_rdata / d_err  out  1/32/1  data response, as fetch.
REQ-020 mem_we, mem_address, mem_usignext, mem_width, mem_w_data  out  1/32/1/2/32  memory drive.
REQ-021 mem_r_data  in  32  combinational memory read data.

Function
REQ-022 At most one of if_gnt, d_gnt SHALL be high per cycle; a grant requires the matching req.
REQ-023 Priority: data over fetch, except when wait_cnt == MAX_WAIT and both request, then fetch wins.
REQ-024 wait_cnt: +1 (saturating at MAX_WAIT) when if_req high and if_gnt low; cleared on if_gnt or if_req low.
REQ-025 Granted fetch drives mem_address=if_addr, mem_width=10, mem_we=0; granted data drives its fields; no grant: mem_we=0, other mem outputs = data fields.
REQ-026 Error conditions: width 11; half with addr[0]=1; word with addr[1:0]!=0; addr + bytes > SIZE.
REQ-027 Errored request SHALL still be granted, with mem_we forced 0.
REQ-028 Response latency exactly 1 cycle: rvalid high the cycle after grant, for one cycle per grant.
REQ-029 rdata = mem_r_data sampled at grant edge for reads, 0 for stores and errors; err = error condition.
REQ-030 Store responses SHALL assert d_rvalid (write acknowledge) with d_rdata = 0.
REQ-031 Back-to-back grants to either requester every cycle SHALL be supported with no bubble.
REQ-032 A requester SHALL hold req and fields stable until granted; arbiter need not check.

Reset
REQ-033 While rst high: if_gnt, d_gnt, mem_we = 0; rvalids, errs, rdatas, wait_cnt = 0, asynchronously.
REQ-034 Reset asserted in a grant cycle SHALL suppress that write and its response.
REQ-035 First grant possible in the first cycle with rst low.

Verification
REQ-036 Both req every cycle, MAX_WAIT=4 -> grant pattern D,D,D,D,F repeating; never both grants.
REQ-037 d_req store word 0xDEADBEEF @0x10, then load byte signed @0x13 -> d_rdata 0xFFFFFFDE, d_err 0.
REQ-038 d_req load word @0x12 -> granted, mem_we 0, next cycle d_rvalid 1, d_err 1, d_rdata 0.
REQ-039 Store half @SIZE-1 -> d_err 1, no memory byte changed (check @SIZE-1 reads old value).
REQ-040 if_req only, addresses 0,4,8 on consecutive cycles -> if_gnt each cycle, if_rvalid 3 consecutive cycles, data in order.
REQ-041 rst pulsed mid-cycle during granted store -> outputs 0 immediately, target bytes unchanged, wait_cnt 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory.
// Data has priority until fetch has been denied MAX_WAIT cycles in a row.
module mem_arbiter #(
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic        d_usignext,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic        mem_usignext,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  logic [WCW-1:0] r_wait_cnt;
  logic           r_if_rvalid;
  logic [31:0]    r_if_rdata;
  logic           r_if_err;
  logic           r_d_rvalid;
  logic [31:0]    r_d_rdata;
  logic           r_d_err;

  logic           w_fetch_starved;
  logic           w_if_gnt;
  logic           w_d_gnt;
  logic           w_if_err;
  logic           w_d_err;

  // End address is computed in 33 bits so accesses near 2^32 cannot wrap into range.
  function automatic logic f_access_err(input logic [31:0] addr, input logic [1:0] width);
    logic [32:0] v_end;
    logic        v_bad;
    v_end = {1'b0, addr};
    v_bad = 1'b0;
    case (width)
      2'b00: v_end = {1'b0, addr} + 33'd1;
      2'b01: begin
        v_bad = addr[0];
        v_end = {1'b0, addr} + 33'd2;
      end
      2'b10: begin
        v_bad = |addr[1:0];
        v_end = {1'b0, addr} + 33'd4;
      end
      default: v_bad = 1'b1;
    endcase
    return v_bad || (v_end > 33'(SIZE));
  endfunction

  assign w_if_err        = f_access_err(if_addr, 2'b10);
  assign w_d_err         = f_access_err(d_addr, d_width);
  assign w_fetch_starved = (r_wait_cnt == WAIT_SAT);

  // Grants are combinational and forced low while reset is held.
  assign w_d_gnt  = !rst && d_req && !(if_req && w_fetch_starved);
  assign w_if_gnt = !rst && if_req && !w_d_gnt;

  always_comb begin
    mem_we       = 1'b0;
    mem_address  = d_addr;
    mem_width    = d_width;
    mem_usignext = d_usignext;
    mem_w_data   = d_wdata;
    if (w_if_gnt) begin
      mem_address = if_addr;
      mem_width   = 2'b10;
    end else if (w_d_gnt) begin
      mem_we = d_we && !w_d_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (if_req && !w_if_gnt) begin
      if (r_wait_cnt != WAIT_SAT) r_wait_cnt <= r_wait_cnt + WCW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_if_err    <= w_if_gnt && w_if_err;
      r_if_rdata  <= (w_if_gnt && !w_if_err) ? mem_r_data : '0;
      r_d_rvalid  <= w_d_gnt;
      r_d_err     <= w_d_gnt && w_d_err;
      r_d_rdata   <= (w_d_gnt && !d_we && !w_d_err) ? mem_r_data : '0;
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array memory environment, a
// cycle-level reference model checked every negedge, plus directed vectors.
module tb_mem_arbiter;
  localparam int unsigned SIZE     = 1024;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_usignext = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_width = 2'b10;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_we, mem_usignext;
  logic [31:0] mem_address, mem_w_data, mem_r_data;
  logic [1:0]  mem_width;

  always #5 clk = ~clk;

  mem_arbiter #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width),
    .d_usignext(d_usignext), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_address(mem_address), .mem_usignext(mem_usignext),
    .mem_width(mem_width), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory: little-endian bytes, combinational read, write on posedge.
  logic [7:0] mem [SIZE];
  logic [7:0] sh  [SIZE];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < (32'd1 << mem_width) && (64'(mem_address) + 64'(k)) < 64'(SIZE))
          mem[10'(mem_address + k)] <= mem_w_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    logic [31:0] v;
    int unsigned n;
    v = '0;
    n = 32'd1 << mem_width;
    if (mem_width != 2'b11 && (64'(mem_address) + 64'(n)) <= 64'(SIZE)) begin
      for (int unsigned k = 0; k < 4; k++)
        if (k < n) v[8*k +: 8] = mem[10'(mem_address + k)];
      if (!mem_usignext && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!mem_usignext && n == 2) v = {{16{v[15]}}, v[15:0]};
    end
    mem_r_data = v;
  end

  // Reference model: rules written as arithmetic over a shadow byte array.
  function automatic logic m_err(input logic [31:0] addr, input logic [1:0] w);
    longint n;
    n = longint'(1) << w;
    return (w == 2'b11) || ((longint'(addr) % n) != 0) || (longint'(addr) + n > longint'(SIZE));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] w, input logic us);
    longint val;
    int     n;
    val = 0;
    n = 1 << w;
    for (int i = n - 1; i >= 0; i--) val = val * 256 + longint'(sh[10'(addr + 32'(i))]);
    if (!us && n < 4 && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
    return 32'(val);
  endfunction

  int          m_wait = 0, n_wait = 0;
  logic        m_if_rv = 0, m_if_err = 0, m_d_rv = 0, m_d_err = 0;
  logic [31:0] m_if_rd = '0, m_d_rd = '0;
  logic        n_if_rv = 0, n_if_err = 0, n_d_rv = 0, n_d_err = 0;
  logic [31:0] n_if_rd = '0, n_d_rd = '0;
  logic        n_wr = 0;
  logic [31:0] n_wa = '0, n_wd = '0;
  logic [1:0]  n_ww = '0;

  always @(negedge clk) begin
    logic e_ig, e_dg, e_ie, e_de;
    if (rst) begin
      chk1("rst_if_gnt", if_gnt, 1'b0);
      chk1("rst_d_gnt", d_gnt, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_if_rvalid", if_rvalid, 1'b0);
      chk1("rst_d_rvalid", d_rvalid, 1'b0);
      chk1("rst_if_err", if_err, 1'b0);
      chk1("rst_d_err", d_err, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      n_wait <= 0; n_if_rv <= 0; n_if_err <= 0; n_if_rd <= '0;
      n_d_rv <= 0; n_d_err <= 0; n_d_rd <= '0; n_wr <= 0;
    end else begin
      e_dg = d_req && !(if_req && m_wait == MAX_WAIT);
      e_ig = if_req && !e_dg;
      e_ie = m_err(if_addr, 2'b10);
      e_de = m_err(d_addr, d_width);
      chk1("if_gnt", if_gnt, e_ig);
      chk1("d_gnt", d_gnt, e_dg);
      chk1("never_both_gnt", if_gnt && d_gnt, 1'b0);
      chk1("mem_we", mem_we, e_dg && d_we && !e_de);
      chk("mem_address", mem_address, e_ig ? if_addr : d_addr);
      chk("mem_width", 32'(mem_width), e_ig ? 32'd2 : 32'(d_width));
      if (e_dg) begin
        chk("mem_w_data", mem_w_data, d_wdata);
        chk1("mem_usignext", mem_usignext, d_usignext);
      end
      chk1("if_rvalid", if_rvalid, m_if_rv);
      chk1("if_err", if_err, m_if_err);
      chk("if_rdata", if_rdata, m_if_rd);
      chk1("d_rvalid", d_rvalid, m_d_rv);
      chk1("d_err", d_err, m_d_err);
      chk("d_rdata", d_rdata, m_d_rd);
      n_if_rv  <= e_ig;
      n_if_err <= e_ig && e_ie;
      n_if_rd  <= (e_ig && !e_ie) ? m_load(if_addr, 2'b10, 1'b1) : '0;
      n_d_rv   <= e_dg;
      n_d_err  <= e_dg && e_de;
      n_d_rd   <= (e_dg && !d_we && !e_de) ? m_load(d_addr, d_width, d_usignext) : '0;
      n_wr     <= e_dg && d_we && !e_de;
      n_wa     <= d_addr;
      n_wd     <= d_wdata;
      n_ww     <= d_width;
      n_wait   <= (if_req && !e_ig) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 0; m_if_rv <= 0; m_if_err <= 0; m_if_rd <= '0;
      m_d_rv <= 0; m_d_err <= 0; m_d_rd <= '0;
    end else begin
      m_wait <= n_wait; m_if_rv <= n_if_rv; m_if_err <= n_if_err; m_if_rd <= n_if_rd;
      m_d_rv <= n_d_rv; m_d_err <= n_d_err; m_d_rd <= n_d_rd;
      if (n_wr)
        for (int k = 0; k < (1 << n_ww); k++) sh[10'(n_wa + 32'(k))] <= n_wd[8*k +: 8];
    end
  end

  // Issue one data request (called just after a posedge); returns the response.
  task automatic d_op(input logic we, input logic [31:0] addr, input logic [1:0] w,
                      input logic us, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e);
    int n;
    n = 0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_width = w; d_usignext = us; d_wdata = wd;
    @(negedge clk);
    while (!d_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("d_op_granted", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk1("d_op_rvalid", d_rvalid, 1'b1);
    rd = d_rdata;
    e  = d_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        e;
  logic [9:0]  pf, pd;

  initial begin
    for (int unsigned i = 0; i < SIZE; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2]  = 8'h33; mem[3]  = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6]  = 8'h77; mem[7]  = 8'h88;
    mem[8] = 8'h99; mem[9] = 8'hAA; mem[10] = 8'hBB; mem[11] = 8'hCC;
    for (int unsigned i = 32'h40; i < 32'h44; i++) mem[i] = 8'hA5;
    mem[1020] = 8'h01; mem[1021] = 8'h02; mem[1022] = 8'h03; mem[1023] = 8'h5A;
    for (int unsigned i = 0; i < SIZE; i++) sh[i] = mem[i];

    repeat (2) @(posedge clk);
    #1;
    chk1("reset_if_rvalid", if_rvalid, 1'b0);
    chk("reset_d_rdata", d_rdata, 32'h0);

    // Fetch-only stream starting in the first cycle out of reset: 0, 4, 8.
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk); chk1("first_cycle_if_gnt", if_gnt, 1'b1);
    @(posedge clk); #1 if_addr = 32'h4;
    @(negedge clk); chk1("fetch1_gnt", if_gnt, 1'b1); chk1("fetch0_rvalid", if_rvalid, 1'b1);
    chk("fetch0_rdata", if_rdata, 32'h44332211);
    @(posedge clk); #1 if_addr = 32'h8;
    @(negedge clk); chk1("fetch1_rvalid", if_rvalid, 1'b1); chk("fetch1_rdata", if_rdata, 32'h88776655);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk); chk1("fetch2_rvalid", if_rvalid, 1'b1); chk("fetch2_rdata", if_rdata, 32'hCCBBAA99);
    @(posedge clk); #1;
    @(negedge clk); chk1("fetch_idle_rvalid", if_rvalid, 1'b0);

    // Misaligned fetch.
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h6;
    @(negedge clk); chk1("fetch_mis_gnt", if_gnt, 1'b1);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk); chk1("fetch_mis_err", if_err, 1'b1); chk("fetch_mis_rdata", if_rdata, 32'h0);
    @(posedge clk); #1;

    d_op(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, e);
    chk("store_ack_rdata", rd, 32'h0); chk1("store_ack_err", e, 1'b0);
    d_op(1'b0, 32'h13, 2'b00, 1'b0, '0, rd, e);
    chk("ldb_signed", rd, 32'hFFFFFFDE); chk1("ldb_signed_err", e, 1'b0);
    d_op(1'b0, 32'h13, 2'b00, 1'b1, '0, rd, e);
    chk("ldb_unsigned", rd, 32'h000000DE);
    d_op(1'b0, 32'h12, 2'b01, 1'b0, '0, rd, e);
    chk("ldh_signed", rd, 32'hFFFFDEAD);
    d_op(1'b0, 32'h12, 2'b10, 1'b0, '0, rd, e);
    chk1("ldw_mis_err", e, 1'b1); chk("ldw_mis_rdata", rd, 32'h0);
    d_op(1'b1, SIZE - 1, 2'b01, 1'b0, 32'h00001234, rd, e);
    chk1("sth_oob_err", e, 1'b1);
    d_op(1'b0, SIZE - 1, 2'b00, 1'b1, '0, rd, e);
    chk("top_byte_unchanged", rd, 32'h0000005A); chk1("top_byte_err", e, 1'b0);
    d_op(1'b0, SIZE - 4, 2'b10, 1'b1, '0, rd, e);
    chk("last_word", rd, 32'h5A030201); chk1("last_word_err", e, 1'b0);
    d_op(1'b0, SIZE, 2'b00, 1'b1, '0, rd, e);
    chk1("past_end_err", e, 1'b1);
    d_op(1'b0, 32'h20, 2'b11, 1'b1, '0, rd, e);
    chk1("illegal_width_err", e, 1'b1);

    // Both requesting every cycle.
    if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_width = 2'b10; d_usignext = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pf[i] = if_gnt;
      pd[i] = d_gnt;
    end
    chk("pattern_fetch", 32'(pf), 32'h210);
    chk("pattern_data", 32'(pd), 32'h1EF);
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;

    // Reset in the middle of a granted store, with fetch already starved 3 cycles.
    @(posedge clk); #1 if_req = 1'b1; d_req = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h11223344;
    #1 chk1("pre_rst_store_we", mem_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("midrst_mem_we", mem_we, 1'b0);
    chk1("midrst_d_gnt", d_gnt, 1'b0);
    chk1("midrst_if_gnt", if_gnt, 1'b0);
    chk1("midrst_d_rvalid", d_rvalid, 1'b0);
    d_we = 1'b0; d_addr = 32'h14;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pf[i] = if_gnt;
    end
    chk("post_rst_pattern", 32'(pf[4:0]), 32'h10);
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    d_op(1'b0, 32'h40, 2'b10, 1'b1, '0, rd, e);
    chk("rst_store_suppressed", rd, 32'hA5A5A5A5);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
